// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch block: FSM states, reset vector
// default, J-type field positions and PC target helpers.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    StBoot  = 2'd0,
    StFetch = 2'd1,
    StExec  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] ResetVectorDefault = 32'h0000_0000;

  // J-type instruction index field
  localparam int unsigned JIdxMsb   = 25;
  localparam int unsigned JIdxLsb   = 0;
  localparam int unsigned JIdxWidth = JIdxMsb - JIdxLsb + 1;

  function automatic logic [31:0] branch_target(input logic [31:0] pc_plus4,
                                                input logic [31:0] sext_imm);
    return pc_plus4 + (sext_imm << 2);
  endfunction

  function automatic logic [31:0] jump_target(input logic [3:0]           pc_hi,
                                              input logic [JIdxWidth-1:0] jidx);
    return {pc_hi, jidx, 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_next_pc_logic.sv
// Combinational next-PC selection: jr, then jump, then branch, then sequential.
module next_pc_logic
  import instr_fetch_pkg::*;
(
  input  logic [31:0]          pc_i,
  input  logic [JIdxWidth-1:0] jidx_i,
  input  logic [31:0]          sext_imm_i,
  input  logic                 branch_taken_i,
  input  logic                 jump_i,
  input  logic                 jr_i,
  input  logic [31:0]          jr_target_i,
  output logic [31:0]          pc_plus4_o,
  output logic [31:0]          next_pc_o,
  output logic                 jr_misalign_o
);

  always_comb begin
    pc_plus4_o    = pc_i + 32'd4;
    next_pc_o     = pc_plus4_o;
    jr_misalign_o = 1'b0;
    if (jr_i) begin
      // Low bits are forced to zero; misalignment is only flagged
      next_pc_o     = {jr_target_i[31:2], 2'b00};
      jr_misalign_o = (jr_target_i[1:0] != 2'b00);
    end else if (jump_i) begin
      next_pc_o = jump_target(pc_plus4_o[31:28], jidx_i);
    end else if (branch_taken_i) begin
      next_pc_o = branch_target(pc_plus4_o, sext_imm_i);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: BOOT/FETCH/EXEC sequencer owning the PC and the
// instruction register, with next-PC selection in a combinational sub-block.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = ResetVectorDefault
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [15:0] imm16,
  input  logic [31:0] sext_imm,
  output logic [31:0] pc_plus4,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic        misalign
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  instr_q;
  logic         instr_valid_q;
  logic         imem_req_q;
  logic         misalign_q;

  logic [31:0]  next_pc_d;
  logic         jr_misalign;

  next_pc_logic u_next_pc_logic (
    .pc_i           (pc_q),
    .jidx_i         (instr_q[JIdxMsb:JIdxLsb]),
    .sext_imm_i     (sext_imm),
    .branch_taken_i (branch_taken),
    .jump_i         (jump),
    .jr_i           (jr),
    .jr_target_i    (jr_target),
    .pc_plus4_o     (pc_plus4),
    .next_pc_o      (next_pc_d),
    .jr_misalign_o  (jr_misalign)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StBoot;
      pc_q          <= RESET_VECTOR;
      instr_q       <= 32'h0;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      unique case (state_q)
        StBoot: begin
          state_q    <= StFetch;
          imem_req_q <= 1'b1;
        end
        StFetch: begin
          if (imem_ack) begin
            instr_q       <= imem_rdata;
            instr_valid_q <= 1'b1;
            imem_req_q    <= 1'b0;
            state_q       <= StExec;
          end
        end
        StExec: begin
          // Redirect inputs only matter on the cycle the PC actually advances
          if (!stall) begin
            pc_q          <= next_pc_d;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b1;
            misalign_q    <= jr_misalign;
            state_q       <= StFetch;
          end
        end
        default: begin
          state_q    <= StBoot;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign imm16       = instr_q[15:0];
  assign misalign    = misalign_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] instr;
  logic        instr_valid;
  logic [15:0] imm16;
  logic [31:0] sext_imm;
  logic [31:0] pc_plus4;
  logic        stall;
  logic        branch_taken;
  logic        jump;
  logic        jr;
  logic [31:0] jr_target;
  logic        misalign;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Stand-in for the external sign-extend stage
  assign sext_imm = {{16{imm16[15]}}, imm16};

  instr_fetch #(
    .RESET_VECTOR (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ack     (imem_ack),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .imm16        (imm16),
    .sext_imm     (sext_imm),
    .pc_plus4     (pc_plus4),
    .stall        (stall),
    .branch_taken (branch_taken),
    .jump         (jump),
    .jr           (jr),
    .jr_target    (jr_target),
    .misalign     (misalign)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a request, then acknowledge it one cycle later.
  task automatic do_fetch(input logic [31:0] word);
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (imem_req !== 1'b1) begin
      failures++;
      $display("FAIL fetch_req_timeout got=%b exp=1", imem_req);
    end
    imem_rdata = word;
    imem_ack   = 1'b1;
    tick();
    imem_ack   = 1'b0;
  endtask

  task automatic exec_step(input logic j_r, input logic j_p, input logic b_r,
                           input logic [31:0] tgt);
    jr           = j_r;
    jump         = j_p;
    branch_taken = b_r;
    jr_target    = tgt;
    tick();
    jr           = 1'b0;
    jump         = 1'b0;
    branch_taken = 1'b0;
    jr_target    = 32'h0;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++;
    if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    checks++;
    if (instr_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
    checks++;
    if (instr !== 32'h0) begin failures++; $display("FAIL rst_instr got=%h exp=0", instr); end
    checks++;
    if (imem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
    checks++;
    if (misalign !== 1'b0) begin failures++; $display("FAIL rst_misalign got=%b exp=0", misalign); end
    rst = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin failures++; $display("FAIL boot_req got=%b exp=0", imem_req); end
    tick();
    checks++;
    if (imem_req !== 1'b1) begin failures++; $display("FAIL boot_to_fetch got=%b exp=1", imem_req); end
  endtask

  task automatic test_first_fetch();
    checks++;
    if (imem_addr !== 32'h0) begin failures++; $display("FAIL first_addr got=%h exp=0", imem_addr); end
    do_fetch(32'h2008_0005);
    checks++;
    if (instr_valid !== 1'b1) begin failures++; $display("FAIL first_valid got=%b exp=1", instr_valid); end
    checks++;
    if (instr !== 32'h2008_0005) begin failures++; $display("FAIL first_instr got=%h exp=20080005", instr); end
    checks++;
    if (imm16 !== 16'h0005) begin failures++; $display("FAIL first_imm16 got=%h exp=0005", imm16); end
    checks++;
    if (imem_req !== 1'b0) begin failures++; $display("FAIL exec_req got=%b exp=0", imem_req); end
    checks++;
    if (pc_plus4 !== 32'h4) begin failures++; $display("FAIL first_pc_plus4 got=%h exp=4", pc_plus4); end
    exec_step(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (imem_addr !== 32'h4) begin failures++; $display("FAIL seq_addr got=%h exp=4", imem_addr); end
    checks++;
    if (imem_req !== 1'b1 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL seq_req_valid got=%b%b exp=10", imem_req, instr_valid);
    end
  endtask

  task automatic test_branch();
    do_fetch(32'h0);
    exec_step(1'b1, 1'b0, 1'b0, 32'h0000_0100);
    checks++;
    if (imem_addr !== 32'h100) begin failures++; $display("FAIL jr_addr got=%h exp=100", imem_addr); end
    checks++;
    if (misalign !== 1'b0) begin failures++; $display("FAIL jr_aligned_misalign got=%b exp=0", misalign); end
    do_fetch(32'h1000_FFFF);
    checks++;
    if (imm16 !== 16'hFFFF) begin failures++; $display("FAIL br_imm16 got=%h exp=FFFF", imm16); end
    exec_step(1'b0, 1'b0, 1'b1, 32'h0);
    checks++;
    if (imem_addr !== 32'h100) begin failures++; $display("FAIL br_neg_addr got=%h exp=100", imem_addr); end
    do_fetch(32'h1000_0003);
    exec_step(1'b0, 1'b0, 1'b1, 32'h0);
    checks++;
    if (imem_addr !== 32'h110) begin failures++; $display("FAIL br_pos_addr got=%h exp=110", imem_addr); end
  endtask

  task automatic test_jump();
    do_fetch(32'h0);
    exec_step(1'b1, 1'b0, 1'b0, 32'h0040_0000);
    do_fetch(32'h0810_0010);
    checks++;
    if (pc_plus4 !== 32'h0040_0004) begin
      failures++;
      $display("FAIL jmp_pc_plus4 got=%h exp=00400004", pc_plus4);
    end
    exec_step(1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (imem_addr !== 32'h0040_0040) begin
      failures++;
      $display("FAIL jmp_addr got=%h exp=00400040", imem_addr);
    end
  endtask

  task automatic test_priority();
    do_fetch(32'h0800_0001);
    checks++;
    if (misalign !== 1'b0) begin failures++; $display("FAIL pri_pre_misalign got=%b exp=0", misalign); end
    exec_step(1'b1, 1'b1, 1'b1, 32'h0000_0203);
    checks++;
    if (imem_addr !== 32'h200) begin failures++; $display("FAIL pri_addr got=%h exp=200", imem_addr); end
    checks++;
    if (misalign !== 1'b1) begin failures++; $display("FAIL pri_misalign got=%b exp=1", misalign); end
    tick();
    checks++;
    if (misalign !== 1'b0) begin failures++; $display("FAIL pri_misalign_pulse got=%b exp=0", misalign); end
  endtask

  task automatic test_stall();
    do_fetch(32'h1234_5678);
    stall     = 1'b1;
    jr        = 1'b1;
    jr_target = 32'h0000_0800;
    for (int i = 0; i < 3; i++) begin
      imem_ack   = (i == 1);
      imem_rdata = 32'hFFFF_FFFF;
      tick();
      checks++;
      if (imem_addr !== 32'h200 || instr !== 32'h1234_5678 || instr_valid !== 1'b1 ||
          imem_req !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold[%0d] addr=%h instr=%h valid=%b req=%b exp=200/12345678/1/0",
                 i, imem_addr, instr, instr_valid, imem_req);
      end
    end
    imem_ack  = 1'b0;
    jr        = 1'b0;
    jr_target = 32'h0;
    stall     = 1'b0;
    tick();
    checks++;
    if (imem_addr !== 32'h204 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_release addr=%h req=%b valid=%b exp=204/1/0",
               imem_addr, imem_req, instr_valid);
    end
  endtask

  task automatic test_reset_mid_fetch();
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h204) begin
      failures++;
      $display("FAIL pre_rst_fetch req=%b addr=%h exp=1/204", imem_req, imem_addr);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr !== 32'h0 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_rst req=%b addr=%h instr=%h valid=%b exp=0/0/0/0",
               imem_req, imem_addr, instr, instr_valid);
    end
    tick();
    rst        = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack   = 1'b0;
    checks++;
    if (instr !== 32'h0 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL late_ack instr=%h valid=%b exp=0/0", instr, instr_valid);
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL restart req=%b addr=%h exp=1/0", imem_req, imem_addr);
    end
  endtask

  task automatic test_wrap();
    do_fetch(32'h0);
    exec_step(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC);
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL wrap_setup got=%h exp=FFFFFFFC", imem_addr);
    end
    checks++;
    if (pc_plus4 !== 32'h0) begin failures++; $display("FAIL wrap_pc_plus4 got=%h exp=0", pc_plus4); end
    do_fetch(32'h0);
    exec_step(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_addr got=%h exp=0", imem_addr); end
  endtask

  initial begin
    rst          = 1'b1;
    imem_rdata   = 32'h0;
    imem_ack     = 1'b0;
    stall        = 1'b0;
    branch_taken = 1'b0;
    jump         = 1'b0;
    jr           = 1'b0;
    jr_target    = 32'h0;
    test_reset();
    test_first_fetch();
    test_branch();
    test_jump();
    test_priority();
    test_stall();
    test_reset_mid_fetch();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_VECTOR, 32'h0000_0000: PC value loaded on reset; bits [1:0] SHALL be zero.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 imem_req  output  1  fetch request to instruction memory.
REQ-005 imem_addr  output  32  byte address of fetch, equals pc.
REQ-006 imem_rdata  input  32  fetched word, valid when imem_ack=1.
REQ-007 imem_ack  input  1  memory completion strobe, variable latency >=1 cycle.
REQ-008 instr  output  32  instruction register contents.
REQ-009 instr_valid  output  1  instr holds a live instruction for decode/execute.
REQ-010 imm16  output  16  instr[15:0], sent to the sign-extend stage.
REQ-011 sext_imm  input  32  sign-extended imm16 returned by the sign-extend stage (combinational).
REQ-012 pc_plus4  output  32  pc + 4, for link/branch use.
REQ-013 stall  input  1  hold current instruction; PC does not advance.
REQ-014 branch_taken  input  1  take PC-relative branch.
REQ-015 jump  input  1  take J-type absolute jump.
REQ-016 jr  input  1  take register jump.
REQ-017 jr_target  input  32  register jump address.
REQ-018 misalign  output  1  one-cycle pulse when jr_target[1:0] != 0 is taken.

Function
REQ-019 FSM SHALL have three states: BOOT, FETCH, EXEC.
REQ-020 BOOT: entered on reset; imem_req=0; SHALL go to FETCH on the next edge unconditionally.
REQ-021 FETCH: imem_req=1, imem_addr=pc; on imem_ack=1, instr<=imem_rdata, instr_valid<=1, go to EXEC; otherwise stay.
REQ-022 EXEC: imem_req=0; if stall=1, remain with instr, pc and instr_valid unchanged; else pc<=next_pc, instr_valid<=0, go to FETCH.
REQ-023 imem_ack outside FETCH SHALL be ignored; it SHALL NOT change instr.
REQ-024 next_pc priority: jr, then jump, then branch_taken, then pc_plus4; redirect inputs are sampled only in EXEC with stall=0.
REQ-025 Branch target = pc_plus4 + (sext_imm << 2), modulo 2^32.
REQ-026 Jump target = {pc_plus4[31:28], instr[25:0], 2'b00}.
REQ-027 jr target = {jr_target[31:2], 2'b00}; misalign SHALL pulse in the cycle the misaligned jr is taken.
REQ-028 pc_plus4 and all targets wrap modulo 2^32; pc 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-029 imm16 SHALL follow instr combinationally; sext_imm is used only while in EXEC.
REQ-030 Fetch latency: instr_valid rises on the edge at which imem_ack=1 is sampled in FETCH. Minimum instruction period is 2 cycles.

Reset
REQ-031 On rst=1, asynchronously: state=BOOT, pc=RESET_VECTOR, instr=0, instr_valid=0, imem_req=0, misalign=0.
REQ-032 Reset during FETCH SHALL abort the fetch. A late imem_ack arriving after reset SHALL be ignored, because the block is in BOOT.

Structure
REQ-033 State encodings, RESET_VECTOR default and J-type field positions SHALL live in the shared cpu package/include file.
REQ-034 Next-PC selection SHALL be a combinational sub-module next_pc_logic. Sign extension stays in the existing external stage.

Verification
REQ-035 Reset, then imem_ack after 1 cycle with rdata=32'h2008_0005 -> imem_addr=0, instr_valid=1, imm16=16'h0005, next fetch at 0x4.
REQ-036 pc=0x100 and branch_taken with imm16=16'hFFFF (sext 32'hFFFF_FFFF) -> next imem_addr=0x100.
REQ-037 pc=0x0040_0000, jump, instr=32'h0810_0010 -> next imem_addr=0x0040_0040.
REQ-038 jr, jump and branch all asserted together, with jr_target=0x203 -> next imem_addr=0x200 and misalign pulses for one cycle.
REQ-039 stall held 3 cycles in EXEC -> pc, instr and instr_valid unchanged and imem_req=0 throughout; advance occurs on release.
REQ-040 rst asserted mid-FETCH, then ack arrives in BOOT -> instr stays 0, fetch restarts at RESET_VECTOR; plus a wrap case from pc=0xFFFF_FFFC -> next imem_addr=0.
